// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, state/channel enums and the setpoint clamp
// used by the servo frame scheduler, its tick generator and its bus interface.
package servo_pkg;

  localparam int CENTER  = 500;
  localparam int MAX_VAL = 1000;
  localparam int PWM_W   = 15;
  localparam int SP_W    = 10;

  typedef enum logic {RUN, LOAD} state_e;
  typedef enum logic {CH_STEER, CH_THROT} ch_e;

  // Setpoints above full scale saturate rather than wrap.
  function automatic logic [SP_W-1:0] clamp_sp(input logic [SP_W-1:0] v);
    return (v > SP_W'(MAX_VAL)) ? SP_W'(MAX_VAL) : v;
  endfunction

endpackage

// File: rtl/servo_frame_sched_if.sv
// servo_frame_sched_if: setpoint handshake plus PWM/status outputs of the
// servo frame scheduler.
//   master : setpoint source (drives sp_valid/sp_ch/sp_val, observes the rest)
//   slave  : the scheduler
interface servo_frame_sched_if;
  import servo_pkg::*;

  logic             sp_valid;
  logic             sp_ch;
  logic [SP_W-1:0]  sp_val;
  logic             sp_ready;
  logic [1:0]       pwm;
  logic             frame_start;
  logic [1:0]       failsafe;
  logic [PWM_W-1:0] frame_tick;

  modport master (
    output sp_valid, sp_ch, sp_val,
    input  sp_ready, pwm, frame_start, failsafe, frame_tick
  );

  modport slave (
    input  sp_valid, sp_ch, sp_val,
    output sp_ready, pwm, frame_start, failsafe, frame_tick
  );
endinterface

// File: rtl/servo_tick_gen.sv
// servo_tick_gen: clk-to-tick prescaler and the per-frame tick counter.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   o_frame_tick   current tick index within the frame
//   o_tick_nxt     value frame_tick takes at the next o_tick_en edge
//   o_tick_en      frame_tick updates (or is initialised) at the next edge
//   o_last_clk     the next clk is the last clk of the frame; one clk early
//                  so the scheduler's state register sits in LOAD during it
//   o_frame_start  registered, high in the first clk of every frame
// Counters hold for one clk after reset so that clk is the first clk of frame 0.
module servo_tick_gen
  import servo_pkg::*;
#(
  parameter int DIV         = 100,
  parameter int FRAME_TICKS = 20000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PWM_W-1:0] o_frame_tick,
  output logic [PWM_W-1:0] o_tick_nxt,
  output logic             o_tick_en,
  output logic             o_last_clk,
  output logic             o_frame_start
);

  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_PEN   = PRE_W'(DIV - 2);
  localparam logic [PWM_W-1:0] TICK_LAST = PWM_W'(FRAME_TICKS - 1);

  logic             r_run;
  logic [PRE_W-1:0] r_presc;
  logic [PWM_W-1:0] r_tick;
  logic             r_frame_start;

  assign o_tick_en     = !r_run || (r_presc == PRE_LAST);
  assign o_tick_nxt    = (!r_run || (r_tick == TICK_LAST)) ? '0 : r_tick + PWM_W'(1);
  assign o_last_clk    = r_run && (r_tick == TICK_LAST) && (r_presc == PRE_PEN);
  assign o_frame_tick  = r_tick;
  assign o_frame_start = r_frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run         <= 1'b0;
      r_presc       <= '0;
      r_tick        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_frame_start <= o_tick_en && (o_tick_nxt == '0);
      if (r_run) begin
        if (r_presc == PRE_LAST) begin
          r_presc <= '0;
          r_tick  <= o_tick_nxt;
        end else begin
          r_presc <= r_presc + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/servo_frame_sched.sv
// servo_frame_sched: two-channel servo frame scheduler and setpoint controller.
// Setpoints arrive on a valid/ready handshake into per-channel shadow
// registers and are copied to the pulse-defining active registers only in
// the last clk of a frame, so a pulse is never altered mid-frame. A channel
// with no write for TIMEOUT_FRAMES frames is recentred and flagged failsafe.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   bus        servo_frame_sched_if.slave: sp_valid/sp_ch/sp_val/sp_ready,
//              pwm[1:0], frame_start, failsafe[1:0], frame_tick
// Build option: SERVO_SLEW_EN limits the per-frame change of each active
// setpoint to SLEW_STEP; failsafe recentring is always immediate.
//
// state | meaning
// RUN   | normal frame, handshake open
// LOAD  | last clk of frame, handshake closed, shadow -> active, ageing
module servo_frame_sched
  import servo_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int TICK_HZ        = 1_000_000,
  parameter int FRAME_TICKS    = 20000,
  parameter int MIN_PULSE      = 1000,
  parameter int TIMEOUT_FRAMES = 25,
  parameter int SLEW_STEP      = 50
) (
  input logic                 clk,
  input logic                 rst,
  servo_frame_sched_if.slave  bus
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int AGE_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_FRAMES);
`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  logic [PWM_W-1:0] w_frame_tick;
  logic [PWM_W-1:0] w_tick_nxt;
  logic             w_tick_en;
  logic             w_last_clk;
  logic             w_frame_start;

  servo_tick_gen #(
    .DIV         (DIV),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_tick_gen (
    .clk           (clk),
    .rst           (rst),
    .o_frame_tick  (w_frame_tick),
    .o_tick_nxt    (w_tick_nxt),
    .o_tick_en     (w_tick_en),
    .o_last_clk    (w_last_clk),
    .o_frame_start (w_frame_start)
  );

  state_e           r_state;
  logic             r_sp_ready;
  logic [SP_W-1:0]  r_shadow [2];
  logic [SP_W-1:0]  r_active [2];
  logic [AGE_W-1:0] r_age    [2];
  logic [1:0]       r_failsafe;
  logic [1:0]       r_pwm;
  logic [PWM_W-1:0] w_limit  [2];
  logic             w_accept;
  ch_e              w_ch;

  assign w_accept = bus.sp_valid && r_sp_ready;
  assign w_ch     = ch_e'(bus.sp_ch);

  function automatic logic [SP_W-1:0] slew_to(input logic [SP_W-1:0] cur,
                                              input logic [SP_W-1:0] tgt);
    logic [SP_W-1:0] step;
    step = SP_W'(SLEW_STEP);
    if (tgt > cur) return ((tgt - cur) > step) ? cur + step : tgt;
    else           return ((cur - tgt) > step) ? cur - step : tgt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_sp_ready <= 1'b0;
      r_failsafe <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        r_shadow[i] <= SP_W'(CENTER);
        r_active[i] <= SP_W'(CENTER);
        r_age[i]    <= AGE_MAX;
      end
    end else begin
      case (r_state)
        RUN: begin
          r_sp_ready <= !w_last_clk;
          if (w_last_clk) r_state <= LOAD;
          if (w_accept) begin
            r_shadow[w_ch] <= clamp_sp(bus.sp_val);
            r_age[w_ch]    <= '0;
          end
        end
        LOAD: begin
          r_state    <= RUN;
          r_sp_ready <= 1'b1;
          for (int i = 0; i < 2; i++) begin
            if (r_age[i] == AGE_MAX) begin
              r_active[i]   <= SP_W'(CENTER);
              r_failsafe[i] <= 1'b1;
            end else begin
              r_active[i]   <= SLEW_ON ? slew_to(r_active[i], r_shadow[i]) : r_shadow[i];
              r_age[i]      <= r_age[i] + AGE_W'(1);
              r_failsafe[i] <= 1'b0;
            end
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_limit[i] = PWM_W'(MIN_PULSE) + PWM_W'(r_active[i]);
    end
  end

  // pwm follows frame_tick in lockstep: at the frame wrap tick_nxt is 0, so
  // both channels rise together regardless of the active value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= '0;
    end else if (w_tick_en) begin
      for (int i = 0; i < 2; i++) begin
        r_pwm[i] <= (w_tick_nxt < w_limit[i]);
      end
    end
  end

  assign bus.sp_ready    = r_sp_ready;
  assign bus.pwm         = r_pwm;
  assign bus.frame_start = w_frame_start;
  assign bus.failsafe    = r_failsafe;
  assign bus.frame_tick  = w_frame_tick;

endmodule

// File: tb/tb_servo_frame_sched.sv
// Testbench for servo_frame_sched with a shortened frame (DIV=2, 1100 ticks,
// MIN_PULSE=50, TIMEOUT_FRAMES=4). Stimulus pushes per-frame expected pulse
// widths and failsafe values; a monitor measures pulses and frame period.
module tb_servo_frame_sched;
  import servo_pkg::*;

  localparam int FT         = 1100;
  localparam int MP         = 50;
  localparam int TO         = 4;
  localparam int DIVB       = 2;
  localparam int FRAME_CLKS = FT * DIVB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servo_frame_sched_if bus_if();

  servo_frame_sched #(
    .CLK_HZ         (2),
    .TICK_HZ        (1),
    .FRAME_TICKS    (FT),
    .MIN_PULSE      (MP),
    .TIMEOUT_FRAMES (TO),
    .SLEW_STEP      (50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int q_w0[$];
  int q_w1[$];
  int q_fs[$];
  int exp_a0[10];
  int exp_a1[10];
  int exp_fs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int width_clks(input int a);
    return (MP + a) * DIVB;
  endfunction

  task automatic push_frame(input int k);
    q_w0.push_back(width_clks(exp_a0[k]));
    q_w1.push_back(width_clks(exp_a1[k]));
    q_fs.push_back(exp_fs[k]);
  endtask

  task automatic next_frame(output int n);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!bus_if.frame_start && n < 2 * FRAME_CLKS + 10);
    if (!bus_if.frame_start) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_wait actual=no_frame_start required=frame_start");
    end
  endtask

  task automatic do_write(input int ch, input int v);
    int n;
    bit acc;
    n = 0;
    bus_if.sp_valid = 1'b1;
    bus_if.sp_ch    = ch[0];
    bus_if.sp_val   = v[9:0];
    do begin
      acc = bus_if.sp_ready;
      @(posedge clk); #2;
      n++;
    end while (!acc && n < 50);
    bus_if.sp_valid = 1'b0;
    check("write_accept", int'(acc), 1);
  endtask

  // Monitor: pulse widths per channel, failsafe and period at frame_start.
  logic [1:0] m_prev = 2'b00;
  int  m_cnt0 = 0;
  int  m_cnt1 = 0;
  int  m_clk = 0;
  int  m_last_fs = 0;
  bit  m_have_fs = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_prev    = 2'b00;
      m_cnt0    = 0;
      m_cnt1    = 0;
      m_have_fs = 1'b0;
    end else begin
      m_clk++;
      if (bus_if.pwm[0]) m_cnt0 = m_prev[0] ? m_cnt0 + 1 : 1;
      else if (m_prev[0]) begin
        if (q_w0.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL pulse_w0 actual=%0d required=no_pulse", m_cnt0);
        end else check("pulse_w0", m_cnt0, q_w0.pop_front());
      end
      if (bus_if.pwm[1]) m_cnt1 = m_prev[1] ? m_cnt1 + 1 : 1;
      else if (m_prev[1]) begin
        if (q_w1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL pulse_w1 actual=%0d required=no_pulse", m_cnt1);
        end else check("pulse_w1", m_cnt1, q_w1.pop_front());
      end
      m_prev = bus_if.pwm;
      if (bus_if.frame_start) begin
        if (m_have_fs) check("frame_period", m_clk - m_last_fs, FRAME_CLKS);
        m_last_fs = m_clk;
        m_have_fs = 1'b1;
        if (q_fs.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL failsafe_frame actual=%0d required=no_frame", bus_if.failsafe);
        end else check("failsafe_frame", int'(bus_if.failsafe), q_fs.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int t;
`ifdef SERVO_SLEW_EN
    exp_a0 = '{500, 550, 600, 650, 600, 550, 500, 450, 500, 500};
    exp_a1 = '{500, 500, 450, 400, 350, 400, 450, 500, 550, 500};
`else
    exp_a0 = '{500, 1000, 1000, 1000, 0, 0, 0, 0, 500, 500};
    exp_a1 = '{500, 500, 0, 0, 0, 800, 800, 800, 800, 500};
`endif
    exp_fs = '{3, 2, 0, 0, 0, 0, 0, 0, 1, 3};

    bus_if.sp_valid = 1'b0;
    bus_if.sp_ch    = 1'b0;
    bus_if.sp_val   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_pwm", int'(bus_if.pwm), 0);
    check("rst_frame_start", int'(bus_if.frame_start), 0);
    check("rst_failsafe", int'(bus_if.failsafe), 3);
    check("rst_sp_ready", int'(bus_if.sp_ready), 0);
    check("rst_frame_tick", int'(bus_if.frame_tick), 0);

    push_frame(0);
    rst = 1'b0;
    next_frame(n);
    check("first_frame_latency", n, 1);
    check("first_pwm", int'(bus_if.pwm), 3);
    check("first_sp_ready", int'(bus_if.sp_ready), 1);

    for (int k = 0; k < 10; k++) begin
      if (k < 9) push_frame(k + 1);
      case (k)
        0: begin
          repeat (100) @(posedge clk);
          #2;
          check("frame_tick_mid", int'(bus_if.frame_tick), 50);
          do_write(0, 1000);
        end
        1: begin
          repeat (100) @(posedge clk);
          #2;
          do_write(0, 1023);
          do_write(1, 0);
        end
        2: begin
          t = 0;
          while (int'(bus_if.frame_tick) != FT - 1 && t < FRAME_CLKS + 10) begin
            @(posedge clk); #2;
            t++;
          end
          check("reach_last_tick", int'(bus_if.frame_tick), FT - 1);
          @(posedge clk); #2;
          check("ready_in_load", int'(bus_if.sp_ready), 0);
          bus_if.sp_valid = 1'b1;
          bus_if.sp_ch    = 1'b0;
          bus_if.sp_val   = '0;
          @(posedge clk); #2;
          check("held_accept_clk", int'(bus_if.frame_start), 1);
          check("ready_after_load", int'(bus_if.sp_ready), 1);
          @(posedge clk); #2;
          bus_if.sp_valid = 1'b0;
        end
        4: begin
          repeat (100) @(posedge clk);
          #2;
          do_write(1, 800);
        end
        9: begin
          repeat (100) @(posedge clk);
          #2;
          check("pwm_before_rst", int'(bus_if.pwm), 3);
          rst = 1'b1;
          @(posedge clk); #2;
          check("rst_mid_pwm", int'(bus_if.pwm), 0);
          check("rst_mid_failsafe", int'(bus_if.failsafe), 3);
          check("rst_mid_frame_tick", int'(bus_if.frame_tick), 0);
          check("rst_mid_sp_ready", int'(bus_if.sp_ready), 0);
          q_w0.delete();
          q_w1.delete();
          q_fs.delete();
          @(posedge clk); #2;
          push_frame(0);
          rst = 1'b0;
          next_frame(n);
          check("restart_latency", n, 1);
          push_frame(0);
          next_frame(n);
          repeat (1200) @(posedge clk);
          #2;
        end
        default: ;
      endcase
      if (k != 2 && k < 9) next_frame(n);
    end

    check("pending_w0", q_w0.size(), 0);
    check("pending_w1", q_w1.size(), 0);
    check("pending_fs", q_fs.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
